booth_mul_dispatcher: RTL and testbench
=======================================

Name: booth_mul_dispatcher

Overview:
Upstream/downstream sequencer for booth_multiplier. It buffers operand pairs in a small FIFO and issues each pair through the multiplier's start/ready handshake. It captures the 16-bit product when the multiplier returns to ready and presents it on a valid/ready result port. The multiplier itself is unchanged; this block owns all handshaking around it.

Parameters:
DEPTH, 4, operand FIFO entries; must be a power of 2 and at least 2
START_TO, 4, clk cycles allowed in ISSUE for mul_ready to drop before a start timeout is flagged; must be at least 2

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  operand pair offered
in_ready  output  1  FIFO can accept; equals (count != DEPTH)
in_a  input  8  multiplicand, two's complement
in_b  input  8  multiplier, two's complement
mul_start  output  1  start command to multiplier
mul_a  output  8  to multiplier a_in
mul_b  output  8  to multiplier b_in
mul_ready  input  1  multiplier ready
mul_result  input  16  multiplier r_out
res_valid  output  1  product available
res_ready  input  1  consumer accepts product
res_data  output  16  captured signed product
busy  output  1  high when FSM is not IDLE or FIFO is not empty
err  output  1  sticky start-timeout flag

Behaviour:
- Reset (reset=0, asynchronous) clears FIFO pointers and count, FSM to IDLE, timer to 0. Outputs: mul_start=0, mul_a=0, mul_b=0, res_valid=0, res_data=0, err=0, busy=0, in_ready=1. A reset mid-operation abandons the operation; any product still in flight in the multiplier is never captured.
- FIFO: push on in_valid&in_ready. Pop happens only on the IDLE->ISSUE transition. in_ready depends on count only, so a push is refused when count==DEPTH even if a pop occurs in the same cycle. Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT_DONE, HOLD.
- IDLE: if count!=0 and mul_ready=1, pop the head into the operand regs (mul_a/mul_b) and go to ISSUE, with the timer cleared. Otherwise stay.
- ISSUE: mul_start=1, and mul_a/mul_b are held stable.
  - If mul_ready=0 is sampled, go to WAIT_DONE.
  - Otherwise increment the timer. When the timer reaches START_TO-1 without mul_ready dropping, set err, drop the operation, and go to IDLE.
- WAIT_DONE: mul_start=0 and the operand regs are held. When mul_ready=1 is sampled, load res_data<=mul_result and go to HOLD.
- HOLD: res_valid=1 and res_data stable. When res_ready=1, go to IDLE; res_valid falls after that edge. res_data keeps its last value until the next capture.
- Latency: a pair pushed at edge E0 into an empty FIFO, with mul_ready=1, gives mul_start high after E1. res_valid rises one edge after mul_ready returns high.
- Ordering: products leave in strict push order. At most one operation is outstanding.
- err stays set until reset and does not block further operations.

Optional Feature:
BOOTH_DISP_ACC_EN
- Defined: adds output acc_out (24 bits, reset 0).
  - On each product capture, acc_out <= acc_out + sign-extended mul_result, wrapping modulo 2^24.
  - acc_out is cleared only by reset.
- Undefined: no acc_out port and no accumulator logic. All other behaviour is identical.

Test Plan:
- Basic: push a=3, b=5 with res_ready=1 and a multiplier model -> exactly one mul_start pulse train with mul_a=3, mul_b=5; res_valid for 1 cycle with res_data=0x000F; busy=0 afterwards.
- Signed: push a=0xFE (-2), b=0x03 -> res_data=0xFFFA. With BOOTH_DISP_ACC_EN defined, a following push of 4x4 gives acc_out=0x00000A.
- Full FIFO: hold in_valid with 6 distinct pairs while the multiplier is busy -> in_ready=0 once count==4. All 6 products come out in push order and none are lost.
- Back-pressure: res_ready=0 for 10 cycles -> res_valid stays 1 with res_data stable. No new mul_start is issued until res_ready=1.
- Timeout: tie mul_ready=1 and push one pair -> mul_start high for START_TO cycles, then err=1, FSM returns to IDLE, FIFO is empty, res_valid never asserts.
- Reset mid WAIT_DONE: assert reset=0 for 1 cycle -> all outputs return to their reset values immediately. A new push after release completes normally.

Source files
------------

// File: rtl/booth_mul_dispatcher.sv
// Operand FIFO plus start/ready sequencer around booth_multiplier, with a valid/ready result port.
// Optional running accumulator of products enabled by defining BOOTH_DISP_ACC_EN.
module booth_mul_dispatcher #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned START_TO = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic        mul_start,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic        mul_ready,
  input  logic [15:0] mul_result,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        busy,
`ifdef BOOTH_DISP_ACC_EN
  output logic        err,
  output logic [23:0] acc_out
`else
  output logic        err
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned TW = $clog2(START_TO);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TO_LAST  = TW'(START_TO - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, HOLD} state_t;

  state_t        state, state_nx;
  logic [7:0]    mem_a [DEPTH];
  logic [7:0]    mem_b [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [TW-1:0] timer;
  logic          push, pop, capture, timeout;

  // in_ready looks at count only, so a full FIFO refuses even when a pop coincides
  assign in_ready = (count != FULL_CNT);
  assign push     = in_valid && in_ready;
  assign pop      = (state == IDLE) && (count != '0) && mul_ready;
  assign capture  = (state == WAIT_DONE) && mul_ready;
  assign timeout  = (state == ISSUE) && mul_ready && (timer == TO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (pop) state_nx = ISSUE;
      ISSUE: begin
        if (!mul_ready)   state_nx = WAIT_DONE;
        else if (timeout) state_nx = IDLE;
      end
      WAIT_DONE: if (mul_ready) state_nx = HOLD;
      HOLD:      if (res_ready) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_comb begin
    mul_start = 1'b0;
    res_valid = 1'b0;
    busy      = (count != '0);
    case (state)
      ISSUE:     begin mul_start = 1'b1; busy = 1'b1; end
      WAIT_DONE: busy = 1'b1;
      HOLD:      begin res_valid = 1'b1; busy = 1'b1; end
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      timer    <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
      res_data <= '0;
      err      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        mul_a  <= mem_a[rd_ptr];
        mul_b  <= mem_b[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (pop)                                         timer <= '0;
      else if (state == ISSUE && mul_ready && !timeout) timer <= timer + 1'b1;
      if (timeout) err      <= 1'b1;
      if (capture) res_data <= mul_result;
    end
  end

`ifdef BOOTH_DISP_ACC_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_out <= '0;
    end else if (capture) begin
      acc_out <= acc_out + {{8{mul_result[15]}}, mul_result};
    end
  end
`endif

endmodule

// File: tb/tb_booth_mul_dispatcher.sv
// Directed bench for booth_mul_dispatcher with a behavioural multiplier model.
// Accumulator check is compiled in only when BOOTH_DISP_ACC_EN is defined.
module tb_booth_mul_dispatcher;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic        mul_start;
  logic [7:0]  mul_a, mul_b;
  logic        mul_ready;
  logic [15:0] mul_result;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_data;
  logic        busy, err;
`ifdef BOOTH_DISP_ACC_EN
  logic [23:0] acc_out;
`endif

  int checks = 0;
  int errors = 0;

  booth_mul_dispatcher #(.DEPTH(4), .START_TO(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_ready(mul_ready), .mul_result(mul_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy),
`ifdef BOOTH_DISP_ACC_EN
    .err(err), .acc_out(acc_out)
`else
    .err(err)
`endif
  );

  always #5 clk = ~clk;

  // Multiplier model: accepts start while ready, stays busy for lat+1 cycles
  logic              model_en = 1'b1;
  int unsigned       lat = 3;
  int unsigned       cnt = 0;
  logic              m_ready = 1'b1;
  logic [15:0]       m_res = '0;
  logic signed [15:0] sa = '0, sb = '0;
  assign mul_ready  = m_ready;
  assign mul_result = m_res;

  always @(negedge clk) begin
    if (!model_en) begin
      m_ready = 1'b1;
      cnt = 0;
    end else if (m_ready && mul_start) begin
      m_ready = 1'b0;
      cnt = lat;
      sa = {{8{mul_a[7]}}, mul_a};
      sb = {{8{mul_b[7]}}, mul_b};
    end else if (!m_ready) begin
      if (cnt == 0) begin
        m_res = sa * sb;
        m_ready = 1'b1;
      end else begin
        cnt--;
      end
    end
  end

  int unsigned start_cnt = 0;
  int unsigned rv_cnt = 0;
  logic [15:0] q_res[$];

  always @(negedge clk) begin
    #2;
    if (mul_start) start_cnt++;
    if (res_valid) rv_cnt++;
    if (res_valid && res_ready) q_res.push_back(res_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  logic saw_full = 1'b0;

  // Called at a negedge; returns at the negedge after the accepting posedge
  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic keep);
    int unsigned n = 0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    while (!in_ready && n < 300) begin
      saw_full = 1'b1;
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("push_timeout", in_ready, 1);
    @(negedge clk);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int unsigned n = 0;
    @(negedge clk);
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check(tag, busy, 0);
  endtask

  task automatic wait_valid(input string tag);
    int unsigned n = 0;
    while (!res_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(tag, res_valid, 1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  logic [7:0]  fa [6] = '{8'h01, 8'h03, 8'h05, 8'hFF, 8'h80, 8'h10};
  logic [7:0]  fb [6] = '{8'h02, 8'h04, 8'h06, 8'h07, 8'h02, 8'h10};
  logic [15:0] fe [6] = '{16'h0002, 16'h000C, 16'h001E, 16'hFFF9, 16'hFF00, 16'h0100};

  initial begin
    int unsigned b_start, b_rv, b_q;

    repeat (3) @(negedge clk);
    check("rst_mul_start", mul_start, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_b", mul_b, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    reset = 1'b1;
    @(negedge clk);

    // Basic 3 x 5
    res_ready = 1'b1;
    lat = 3;
    b_start = start_cnt; b_rv = rv_cnt; b_q = q_res.size();
    push(8'd3, 8'd5, 1'b0);
    @(negedge clk);
    check("basic_start", mul_start, 1);
    check("basic_mul_a", mul_a, 3);
    check("basic_mul_b", mul_b, 5);
    wait_idle("basic_idle");
    check("basic_starts", start_cnt - b_start, 1);
    check("basic_rv_cycles", rv_cnt - b_rv, 1);
    check("basic_count", q_res.size() - b_q, 1);
    check("basic_data", q_res[b_q], 16'h000F);

    // Signed -2 x 3 then 4 x 4, from a fresh reset
    pulse_reset();
    b_q = q_res.size();
    push(8'hFE, 8'h03, 1'b0);
    push(8'h04, 8'h04, 1'b0);
    wait_idle("signed_idle");
    check("signed_count", q_res.size() - b_q, 2);
    check("signed_data0", q_res[b_q], 16'hFFFA);
    check("signed_data1", q_res[b_q+1], 16'h0010);
`ifdef BOOTH_DISP_ACC_EN
    check("signed_acc", acc_out, 24'h00000A);
`endif

    // Full FIFO with in_valid held across six pairs
    lat = 8;
    b_q = q_res.size();
    saw_full = 1'b0;
    for (int i = 0; i < 6; i++) push(fa[i], fb[i], (i != 5));
    check("full_seen", saw_full, 1);
    wait_idle("full_idle");
    check("full_count", q_res.size() - b_q, 6);
    for (int i = 0; i < 6; i++) check($sformatf("full_data%0d", i), q_res[b_q+i], fe[i]);

    // Back-pressure on the result port
    lat = 2;
    res_ready = 1'b0;
    b_q = q_res.size();
    push(8'd7, 8'd9, 1'b0);
    push(8'd2, 8'd3, 1'b0);
    wait_valid("bp_valid");
    b_start = start_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_valid", res_valid, 1);
      check("bp_hold_data", res_data, 16'h003F);
    end
    check("bp_no_start", start_cnt - b_start, 0);
    res_ready = 1'b1;
    wait_idle("bp_idle");
    check("bp_count", q_res.size() - b_q, 2);
    check("bp_data0", q_res[b_q], 16'h003F);
    check("bp_data1", q_res[b_q+1], 16'h0006);

    // Start timeout with mul_ready tied high
    model_en = 1'b0;
    repeat (2) @(negedge clk);
    b_start = start_cnt; b_rv = rv_cnt;
    push(8'd1, 8'd1, 1'b0);
    wait_idle("to_idle");
    check("to_starts", start_cnt - b_start, 4);
    check("to_err", err, 1);
    check("to_no_valid", rv_cnt - b_rv, 0);
    check("to_in_ready", in_ready, 1);
    model_en = 1'b1;
    repeat (2) @(negedge clk);
    b_q = q_res.size();
    push(8'd2, 8'd2, 1'b0);
    wait_idle("to_after_idle");
    check("to_after_count", q_res.size() - b_q, 1);
    check("to_after_data", q_res[b_q], 16'h0004);
    check("to_err_sticky", err, 1);

    // Reset while waiting for the multiplier
    lat = 6;
    push(8'd5, 8'd5, 1'b0);
    repeat (2) @(negedge clk);
    check("rmid_busy", busy, 1);
    reset = 1'b0;
    #1;
    check("rmid_mul_start", mul_start, 0);
    check("rmid_mul_a", mul_a, 0);
    check("rmid_mul_b", mul_b, 0);
    check("rmid_res_valid", res_valid, 0);
    check("rmid_res_data", res_data, 0);
    check("rmid_err", err, 0);
    check("rmid_busy_low", busy, 0);
    check("rmid_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    b_q = q_res.size();
    push(8'd6, 8'd7, 1'b0);
    wait_idle("rmid_idle");
    check("rmid_count", q_res.size() - b_q, 1);
    check("rmid_data", q_res[b_q], 16'h002A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
